ttm4_prog_mem: RTL
==================

# ttm4_prog_mem

Parametrised, loadable program memory for the TTM4 emulator core. Replaces the fixed two-chip read-only instruction store.
- Holds 2^ADDR_W 16-bit instruction words.
- Serves registered instruction fetches with the IM/LR/SR/OP fields decoded.
- Includes a byte-stream loader, so a host can rewrite the program at run time without resynthesis.
- Sits between the CPU sequencer (fetch side) and the host/UART byte source (load side).

## Interface
Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W words (legal 4..12)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- FETCH_REQ  in  1  fetch request, sampled on CLK
- FETCH_ADD  in  ADDR_W  fetch address
- FETCH_VLD  out  1  one-cycle strobe: fetched word/fields valid
- WORD  out  16  raw fetched word
- IM  out  4  WORD[3:0], immediate
- LR  out  3  WORD[6:4], load-register select
- SR  out  3  WORD[9:7], store-register select
- OP  out  5  WORD[14:10], opcode
- LD_START  in  1  pulse: begin load at LD_BASE
- LD_BASE  in  ADDR_W  first load address
- LD_LAST  in  ADDR_W  final load address, inclusive
- LD_BYTE  in  8  load data byte
- LD_STB  in  1  LD_BYTE valid
- LD_BUSY  out  1  load in progress; fetch blocked
- LD_DONE  out  1  one-cycle pulse: LD_LAST written
- LD_ERR  out  1  sticky parity error (PMEM_PARITY_EN only; else 0)

## Operation
- Loader FSM states:
  - IDLE: waits for LD_START.
  - LO: accepts the low byte; latches it into WORD[7:0].
  - HI: accepts the high byte, then writes the word at the pointer.
- Transitions:
  - IDLE→LO on LD_START; pointer is loaded with LD_BASE and LD_BUSY is set.
  - LO→HI on LD_STB.
  - HI→LO on LD_STB, with write and pointer+1.
  - HI→IDLE on LD_STB when the pointer equals LD_LAST, with write, LD_DONE pulse and LD_BUSY cleared.
- Pointer wraps from 2^ADDR_W−1 to 0. LD_LAST < LD_BASE is legal and loads through the wrap.
- LD_START in any state restarts at LO with the new LD_BASE. An LD_STB in the same cycle is discarded.
- LD_STB with no LD_START pending (IDLE) is ignored.
- Fetch:
  - FETCH_REQ with LD_BUSY=0 reads FETCH_ADD.
  - WORD and the fields update, and FETCH_VLD=1, exactly one cycle later.
  - Outputs hold their last value otherwise.
- FETCH_REQ while LD_BUSY=1 is dropped: no FETCH_VLD, outputs unchanged. The sequencer must re-request.
- Field decode is purely from the registered WORD. WORD[15] is not decoded.

## Timing
- Reset values:
  - FETCH_VLD, WORD, IM, LR, SR, OP, LD_BUSY, LD_DONE and LD_ERR are 0.
  - FSM goes to IDLE and the pointer to 0.
  - Memory contents are not cleared.
- Fetch latency: 1 cycle. Back-to-back FETCH_REQ gives one result per cycle.
- Write occurs on the CLK edge that samples the high byte. A fetch of that address issued on the next cycle (LD_BUSY now 0) returns the new word.
- LD_BUSY rises on the cycle after LD_START is sampled. It falls with the LD_DONE pulse.
- RST mid-load aborts: FSM goes to IDLE. Words already written are kept. A partially assembled word is discarded.

## Configuration
- PMEM_PARITY_EN defined:
  - In HI, WORD[15] from the host must equal even parity, i.e. XOR of WORD[14:0].
  - On mismatch the word is not written and LD_ERR sets. The pointer still advances.
  - LD_ERR is sticky until the next LD_START or RST.
- PMEM_PARITY_EN undefined: WORD[15] is stored as supplied with no check, and LD_ERR is tied 0.

## Test plan
- Reset then idle: after RST release, all outputs are 0. FETCH_REQ at address 0x00 gives FETCH_VLD one cycle later.
- Load and fetch:
  - Stimulus: LD_START with LD_BASE=0x10, LD_LAST=0x11; bytes 0x5A,0x2B,0x01,0x80.
  - LD_DONE pulses after the 4th byte.
  - Fetch 0x10 → WORD=0x2B5A, IM=0xA, LR=5, SR=6, OP=0x0A.
  - Fetch 0x11 → WORD=0x8001.
- Wrap (ADDR_W=4): LD_BASE=0xF, LD_LAST=0x0 with 4 bytes writes addresses 0xF and 0x0. LD_DONE pulses once.
- Collision:
  - FETCH_REQ during LD_BUSY gives no FETCH_VLD.
  - LD_START with LD_STB in the same cycle mid-load drops the byte. The next two bytes land at the new LD_BASE.
- Reset mid-load: RST after a low byte only leaves the target address holding its previous contents and LD_BUSY=0.
- Parity (macro on):
  - High byte 0x80 on low byte 0x00 → LD_ERR=1, word not written.
  - High byte 0x00 with low byte 0x00 → accepted.
  - Macro off: both are written and LD_ERR stays 0.

Source files
------------

// File: rtl/ttm4_prog_mem_if.sv
// rtl/ttm4_prog_mem_if.sv - fetch and byte-loader bus of the TTM4 program memory
interface ttm4_prog_mem_if #(
  parameter int ADDR_W = 8
);
  // Fetch side (CPU sequencer)
  logic              FETCH_REQ;
  logic [ADDR_W-1:0] FETCH_ADD;
  logic              FETCH_VLD;
  logic [15:0]       WORD;
  logic [3:0]        IM;
  logic [2:0]        LR;
  logic [2:0]        SR;
  logic [4:0]        OP;
  // Load side (host byte source)
  logic              LD_START;
  logic [ADDR_W-1:0] LD_BASE;
  logic [ADDR_W-1:0] LD_LAST;
  logic [7:0]        LD_BYTE;
  logic              LD_STB;
  logic              LD_BUSY;
  logic              LD_DONE;
  logic              LD_ERR;

  modport master (
    output FETCH_REQ, FETCH_ADD, LD_START, LD_BASE, LD_LAST, LD_BYTE, LD_STB,
    input  FETCH_VLD, WORD, IM, LR, SR, OP, LD_BUSY, LD_DONE, LD_ERR
  );

  modport slave (
    input  FETCH_REQ, FETCH_ADD, LD_START, LD_BASE, LD_LAST, LD_BYTE, LD_STB,
    output FETCH_VLD, WORD, IM, LR, SR, OP, LD_BUSY, LD_DONE, LD_ERR
  );
endinterface

// File: rtl/ttm4_prog_mem.sv
// rtl/ttm4_prog_mem.sv - loadable TTM4 program memory with field decode; PMEM_PARITY_EN enables load parity check
module ttm4_prog_mem #(
  parameter int ADDR_W = 8
) (
  input logic          CLK,
  input logic          RST,
  ttm4_prog_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } ld_state_t;

  ld_state_t         state_q, state_n;
  logic [ADDR_W-1:0] ptr_q, ptr_n;
  logic [7:0]        lo_q, lo_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              hi_stb;
  logic              par_ok;
  logic              we;

  logic [15:0]       mem [0:DEPTH-1];
  logic [15:0]       word_q;
  logic              vld_q;

`ifdef PMEM_PARITY_EN
  // Host sets WORD[15] to the XOR of WORD[14:0]; lo_q holds WORD[7:0].
  assign par_ok = (bus.LD_BYTE[7] == ^{bus.LD_BYTE[6:0], lo_q});
`else
  assign par_ok = 1'b1;
`endif

  assign we = hi_stb & par_ok;

  // Loader state, pointer, assembled low byte and load status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      lo_q    <= lo_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Loader next state: LD_START wins over everything, including a same-cycle byte
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    lo_n    = lo_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    hi_stb  = 1'b0;
    if (bus.LD_START) begin
      state_n = ST_LO;
      ptr_n   = bus.LD_BASE;
      busy_n  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_LO: begin
          if (bus.LD_STB) begin
            lo_n    = bus.LD_BYTE;
            state_n = ST_HI;
          end
        end
        ST_HI: begin
          if (bus.LD_STB) begin
            hi_stb = 1'b1;
            ptr_n  = ptr_q + 1'b1;
            if (ptr_q == bus.LD_LAST) begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = ST_LO;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

`ifdef PMEM_PARITY_EN
  logic err_q;

  // Sticky parity error, cleared only by a new load or reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (bus.LD_START) begin
      err_q <= 1'b0;
    end else if (hi_stb && !par_ok) begin
      err_q <= 1'b1;
    end
  end

  assign bus.LD_ERR = err_q;
`else
  assign bus.LD_ERR = 1'b0;
`endif

  // Word write on the edge that samples the high byte; contents survive reset
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[ptr_q] <= {bus.LD_BYTE, lo_q};
    end
  end

  // Registered fetch; requests arriving while a load is active are dropped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.FETCH_REQ && !busy_q) begin
        word_q <= mem[bus.FETCH_ADD];
        vld_q  <= 1'b1;
      end
    end
  end

  assign bus.FETCH_VLD = vld_q;
  assign bus.WORD      = word_q;
  assign bus.IM        = word_q[3:0];
  assign bus.LR        = word_q[6:4];
  assign bus.SR        = word_q[9:7];
  assign bus.OP        = word_q[14:10];
  assign bus.LD_BUSY   = busy_q;
  assign bus.LD_DONE   = done_q;

endmodule
